// File: rtl/cpu_dbg_mem_port_pkg.sv
// Shared definitions for the CPU debug memory port and its serial command decoder.
`default_nettype none

package cpu_dbg_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_LEN_W  = 8;

  localparam logic [1:0] OP_RD_IM = 2'b00;
  localparam logic [1:0] OP_RD_DM = 2'b01;
  localparam logic [1:0] OP_WR_IM = 2'b10;
  localparam logic [1:0] OP_WR_DM = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_SETUP  = 3'd1,
    S_W_STROBE = 3'd2,
    S_W_HOLD   = 3'd3,
    S_R_SETTLE = 3'd4,
    S_RESP     = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/cpu_dbg_mem_port_if.sv
// Command/response stream between the debug command decoder (master) and the memory port (slave).
`default_nettype none

interface cpu_dbg_mem_port_if
  import cpu_dbg_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_data;
  logic [LEN_W-1:0] cmd_len;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_addr;
  logic [31:0]      rsp_data;
  logic             rsp_last;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last
  );

endinterface

`default_nettype wire

// File: rtl/cpu_dbg_mem_port.sv
// Debug-side initiator for the CPU memory-load port: single-word writes with a
// registered clk_ld strobe, and burst reads sampled after an address settle time.
`default_nettype none

module cpu_dbg_mem_port
  import cpu_dbg_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rstn,
  cpu_dbg_mem_port_if.slave  bus,
  output logic [31:0]        addr,
  output logic [31:0]        din,
  output logic               we_im,
  output logic               we_dm,
  output logic               clk_ld,
  input  logic [31:0]        dout_im,
  input  logic [31:0]        dout_dm,
  output logic               busy
);

  localparam int          SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [31:0] ADDR_MASK = (ADDR_W >= 32) ? 32'hFFFF_FFFF
                                                     : ((32'd1 << ADDR_W) - 32'd1);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      din_q, din_d;
  logic             we_im_q, we_im_d;
  logic             we_dm_q, we_dm_d;
  logic             clk_ld_q, clk_ld_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_addr_q, rsp_addr_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_last_q, rsp_last_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      count_q     <= '0;
      settle_q    <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      we_im_q     <= 1'b0;
      we_dm_q     <= 1'b0;
      clk_ld_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      count_q     <= count_d;
      settle_q    <= settle_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_im_q     <= we_im_d;
      we_dm_q     <= we_dm_d;
      clk_ld_q    <= clk_ld_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    count_d    = count_q;
    settle_d   = settle_q;
    addr_d     = addr_q;
    din_d      = din_q;
    we_im_d    = we_im_q;
    we_dm_d    = we_dm_q;
    clk_ld_d   = 1'b0;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          op_d     = bus.cmd_op;
          din_d    = bus.cmd_data;
          count_d  = (bus.cmd_len == '0) ? LEN_W'(1) : bus.cmd_len;
          addr_d   = bus.cmd_addr & ADDR_MASK;
          settle_d = SW'(SETTLE - 1);
          if (bus.cmd_op[1]) begin
            we_im_d = (bus.cmd_op == OP_WR_IM);
            we_dm_d = (bus.cmd_op == OP_WR_DM);
            state_d = S_W_SETUP;
          end else begin
            state_d = S_R_SETTLE;
          end
        end
      end
      S_W_SETUP: begin
        clk_ld_d = 1'b1;
        state_d  = S_W_STROBE;
      end
      S_W_STROBE: begin
        state_d = S_W_HOLD;
      end
      S_W_HOLD: begin
        we_im_d    = 1'b0;
        we_dm_d    = 1'b0;
        rsp_addr_d = addr_q;
        rsp_data_d = din_q;
        rsp_last_d = 1'b1;
        state_d    = S_RESP;
      end
      S_R_SETTLE: begin
        if (settle_q == '0) begin
          rsp_addr_d = addr_q;
          rsp_data_d = (op_q == OP_RD_DM) ? dout_dm : dout_im;
          rsp_last_d = (count_q == LEN_W'(1));
          state_d    = S_RESP;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          if (rsp_last_q) begin
            state_d = S_IDLE;
          end else begin
            // Next burst word: wrap within the decoded address window.
            count_d  = count_q - LEN_W'(1);
            addr_d   = (addr_q + 32'd1) & ADDR_MASK;
            settle_d = SW'(SETTLE - 1);
            state_d  = S_R_SETTLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_addr  = rsp_addr_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;
  assign addr          = addr_q;
  assign din           = din_q;
  assign we_im         = we_im_q;
  assign we_dm         = we_dm_q;
  assign clk_ld        = clk_ld_q;
  assign busy          = busy_q;

endmodule

`default_nettype wire
